bit_serial_addsub_array: RTL and testbench

//  NUM_LANES independent bit-serial two's-complement adder/subtractors sharing one word framer.

---
 rtl/bsa_pkg.sv | 15 +
 rtl/bit_serial_addsub_array_if.sv | 32 +++
 rtl/bit_serial_lane.sv | 63 ++++++
 rtl/bit_serial_addsub_array.sv | 121 ++++++++++++
 tb/tb_bit_serial_addsub_array.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bsa_pkg.sv
// Shared types and the single-bit full adder used by every serial lane.
package bsa_pkg;

    // Word framer state: waiting for an LSB, or inside a word.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bsa_state_t;

    // One-bit full adder, result packed as {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/bit_serial_addsub_array_if.sv
// Beat-level bus of the bit-serial add/sub array.
// Handshake: a beat is transferred on a posedge where in_valid=1; there is no
// back-pressure. in_first marks bit 0 of a word. Each accepted beat produces
// exactly one out_valid beat one cycle later; out_first/out_last frame the word.
interface bit_serial_addsub_array_if #(
    parameter int NUM_LANES = 8
) ();

    logic                 in_valid;
    logic                 in_first;
    logic [NUM_LANES-1:0] a_bits;
    logic [NUM_LANES-1:0] b_bits;
    logic [NUM_LANES-1:0] sub;
    logic                 out_valid;
    logic                 out_first;
    logic                 out_last;
    logic [NUM_LANES-1:0] sum_bits;
    logic [NUM_LANES-1:0] ovf;

    // Producer of operand beats / consumer of sum beats.
    modport master (
        output in_valid, in_first, a_bits, b_bits, sub,
        input  out_valid, out_first, out_last, sum_bits, ovf
    );

    // The adder array itself.
    modport slave (
        input  in_valid, in_first, a_bits, b_bits, sub,
        output out_valid, out_first, out_last, sum_bits, ovf
    );

endinterface

// File: rtl/bit_serial_lane.sv
// One bit-serial two's-complement adder/subtractor lane.
// Subtraction is A + ~B + 1: B is inverted and the carry is seeded with 1 on the LSB.
// Optional feature macro: BIT_SERIAL_ADDSUB_OVF_EN (signed overflow flag on the MSB).
module bit_serial_lane
    import bsa_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic en,      // beat accepted this cycle
    input  logic first,   // accepted beat is the LSB of a new word
`ifdef BIT_SERIAL_ADDSUB_OVF_EN
    input  logic last,    // accepted beat is the MSB of the word
`endif
    input  logic sub,     // live op, only used on the first beat
    input  logic sub_q,   // op captured on the first beat of the word
    input  logic a,
    input  logic b,
    output logic sum,
`ifdef BIT_SERIAL_ADDSUB_OVF_EN
    output logic ovf,
`endif
    output logic carry_dbg
);

    logic       carry;
    logic       sub_eff;
    logic       bb;
    logic       cin;
    logic [1:0] fa;

    // Operand inversion and carry selection; the first beat re-seeds from the live op.
    always_comb begin
        sub_eff = first ? sub : sub_q;
        bb      = b ^ sub_eff;
        cin     = first ? sub : carry;
        fa      = full_add(a, bb, cin);
    end

    // Carry and sum registers advance only on accepted beats; stalls hold them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            carry <= 1'b0;
            sum   <= 1'b0;
        end else if (en) begin
            carry <= fa[1];
            sum   <= fa[0];
        end
    end

`ifdef BIT_SERIAL_ADDSUB_OVF_EN
    // Signed overflow = carry into MSB xor carry out of MSB; zero on every other beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (en) begin
            ovf <= last ? (cin ^ fa[1]) : 1'b0;
        end
    end
`endif

    assign carry_dbg = carry;

endmodule

// File: rtl/bit_serial_addsub_array.sv
// NUM_LANES bit-serial add/sub lanes sharing one word framer (FSM + bit counter).
// Optional feature macro: BIT_SERIAL_ADDSUB_OVF_EN (per-lane signed overflow on the MSB).
module bit_serial_addsub_array
    import bsa_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int WORD_BITS = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    bit_serial_addsub_array_if.slave      bus,
    output bsa_state_t                    fsm_state,
    output logic [NUM_LANES-1:0]          carry_state
);

    localparam int                CW       = $clog2(WORD_BITS);
    localparam logic [CW-1:0]     LAST_IDX = CW'(WORD_BITS - 1);
    localparam logic [CW-1:0]     ONE      = CW'(1);

    bsa_state_t           state;
    bsa_state_t           state_next;
    logic [CW-1:0]        cnt;
    logic [NUM_LANES-1:0] sub_q;

    logic                 beat_first;
    logic                 beat_acc;
    logic                 beat_last;

    logic                 out_valid_q;
    logic                 out_first_q;
    logic                 out_last_q;
    logic [NUM_LANES-1:0] sum_vec;
    logic [NUM_LANES-1:0] ovf_vec;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: an LSB always lands in RUN, the MSB (without a new LSB) returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat_first) state_next = RUN;
            RUN:     if (beat_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat decode: in IDLE only an LSB is accepted; in RUN every valid beat is.
    always_comb begin
        beat_first = bus.in_valid & bus.in_first;
        beat_acc   = bus.in_valid & (bus.in_first | (state == RUN));
        beat_last  = bus.in_valid & ~bus.in_first & (state == RUN) & (cnt == LAST_IDX);
    end

    // Bit counter and captured op; both hold across stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            sub_q <= '0;
        end else if (beat_first) begin
            cnt   <= ONE;
            sub_q <= bus.sub;
        end else if (beat_last) begin
            cnt   <= '0;
        end else if (beat_acc) begin
            cnt   <= cnt + ONE;
        end
    end

    // Framing outputs, registered alongside the lane sum bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= beat_acc;
            out_first_q <= beat_first;
            out_last_q  <= beat_last;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        bit_serial_lane u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .en        (beat_acc),
            .first     (beat_first),
`ifdef BIT_SERIAL_ADDSUB_OVF_EN
            .last      (beat_last),
`endif
            .sub       (bus.sub[i]),
            .sub_q     (sub_q[i]),
            .a         (bus.a_bits[i]),
            .b         (bus.b_bits[i]),
            .sum       (sum_vec[i]),
`ifdef BIT_SERIAL_ADDSUB_OVF_EN
            .ovf       (ovf_vec[i]),
`endif
            .carry_dbg (carry_state[i])
        );
    end

`ifndef BIT_SERIAL_ADDSUB_OVF_EN
    assign ovf_vec = '0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.sum_bits  = sum_vec;
    assign bus.ovf       = ovf_vec;
    assign fsm_state     = state;

endmodule

// File: tb/tb_bit_serial_addsub_array.sv
// Testbench for bit_serial_addsub_array (NUM_LANES=8, WORD_BITS=8).
// Reference model works on whole words: sum = (A +/- B) mod 256 and signed
// overflow from integer range, then each output beat is checked against bit k.
module tb_bit_serial_addsub_array;
    import bsa_pkg::*;

    localparam int NL = 8;
    localparam int WB = 8;
`ifdef BIT_SERIAL_ADDSUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    bsa_state_t fsm_state;
    logic [NL-1:0] carry_state;

    bit_serial_addsub_array_if #(.NUM_LANES(NL)) bus ();

    bit_serial_addsub_array #(.NUM_LANES(NL), .WORD_BITS(WB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .fsm_state   (fsm_state),
        .carry_state (carry_state)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WB-1:0] wa [NL];
    logic [WB-1:0] wb [NL];
    logic [NL-1:0] wsub;
    logic [WB-1:0] es [NL];
    logic [NL-1:0] eo;
    logic [WB-1:0] got [NL];
    logic [NL-1:0] got_ovf;
    logic [NL-1:0] last_sum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word-level reference model.
    function automatic void model();
        for (int i = 0; i < NL; i++) begin
            int sa;
            int sb;
            int r;
            sa = int'($signed(wa[i]));
            sb = int'($signed(wb[i]));
            r  = wsub[i] ? (sa - sb) : (sa + sb);
            es[i] = r[WB-1:0];
            eo[i] = (r > 127) || (r < -128);
        end
    endfunction

    task automatic new_word();
        for (int i = 0; i < NL; i++) begin
            wa[i] = WB'($urandom);
            wb[i] = WB'($urandom);
        end
        wsub = NL'($urandom);
        model();
    endtask

    // Drive bit k of the current word and check the resulting output beat.
    task automatic drive_bit(input int k, input bit first);
        logic [NL-1:0] exp_sum;
        bus.in_valid = 1'b1;
        bus.in_first = first;
        for (int i = 0; i < NL; i++) begin
            bus.a_bits[i] = wa[i][k];
            bus.b_bits[i] = wb[i][k];
        end
        bus.sub = first ? wsub : NL'($urandom);
        step();
        for (int i = 0; i < NL; i++) exp_sum[i] = es[i][k];
        chk("out_valid", 32'(bus.out_valid), 32'(1));
        chk("out_first", 32'(bus.out_first), 32'(k == 0));
        chk("out_last",  32'(bus.out_last),  32'(k == WB - 1));
        chk("sum_bits",  32'(bus.sum_bits),  32'(exp_sum));
        chk("ovf",       32'(bus.ovf), (k == WB - 1 && OVF_EN) ? 32'(eo) : 32'(0));
        chk("state",     32'(fsm_state), (k == WB - 1) ? 32'(IDLE) : 32'(RUN));
        for (int i = 0; i < NL; i++) got[i][k] = bus.sum_bits[i];
        if (k == WB - 1) got_ovf = bus.ovf;
        last_sum = exp_sum;
    endtask

    // A cycle with no accepted beat: stall in RUN, or a dropped beat in IDLE.
    task automatic idle_cycle(input bit valid, input bsa_state_t exp_state);
        bus.in_valid = valid;
        bus.in_first = valid ? 1'b0 : 1'($urandom);
        bus.a_bits   = NL'($urandom);
        bus.b_bits   = NL'($urandom);
        bus.sub      = NL'($urandom);
        step();
        chk("idle_valid", 32'(bus.out_valid), 32'(0));
        chk("idle_first", 32'(bus.out_first), 32'(0));
        chk("idle_last",  32'(bus.out_last),  32'(0));
        chk("idle_hold",  32'(bus.sum_bits),  32'(last_sum));
        chk("idle_state", 32'(fsm_state),     32'(exp_state));
    endtask

    task automatic full_word();
        for (int k = 0; k < WB; k++) drive_bit(k, k == 0);
    endtask

    initial begin
        int gap;
        int p;
        bit abort;

        // Reset
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.a_bits   = '0;
        bus.b_bits   = '0;
        bus.sub      = '0;
        reset_n      = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_first", 32'(bus.out_first), 32'(0));
        chk("rst_last",  32'(bus.out_last),  32'(0));
        chk("rst_sum",   32'(bus.sum_bits),  32'(0));
        chk("rst_ovf",   32'(bus.ovf),       32'(0));
        chk("rst_state", 32'(fsm_state),     32'(IDLE));
        chk("rst_carry", 32'(carry_state),   32'(0));
        reset_n  = 1'b1;
        last_sum = '0;
        idle_cycle(1'b1, IDLE);

        // 1: 0x05 + 0x03 on lane 0
        new_word();
        wa[0] = 8'h05; wb[0] = 8'h03; wsub[0] = 1'b0;
        model();
        full_word();
        chk("t1_word", 32'(got[0]), 32'h08);
        chk("t1_ovf",  32'(got_ovf[0]), 32'(0));

        // 2: lane1 3-5, lane0 0x7F+0x01
        new_word();
        wa[1] = 8'h03; wb[1] = 8'h05; wsub[1] = 1'b1;
        wa[0] = 8'h7F; wb[0] = 8'h01; wsub[0] = 1'b0;
        model();
        full_word();
        chk("t2_word1", 32'(got[1]), 32'hFE);
        chk("t2_ovf1",  32'(got_ovf[1]), 32'(0));
        chk("t2_word0", 32'(got[0]), 32'h80);
        chk("t2_ovf0",  32'(got_ovf[0]), 32'(OVF_EN));
        idle_cycle(1'b0, IDLE);

        // 3: 0x12 + 0x34 with a 3-cycle stall after bit 3
        new_word();
        wa[0] = 8'h12; wb[0] = 8'h34; wsub[0] = 1'b0;
        model();
        for (int k = 0; k < 4; k++) drive_bit(k, k == 0);
        for (int s = 0; s < 3; s++) idle_cycle(1'b0, RUN);
        for (int k = 4; k < WB; k++) drive_bit(k, 1'b0);
        chk("t3_word", 32'(got[0]), 32'h46);

        // 4: back-to-back words
        new_word();
        full_word();
        new_word();
        full_word();

        // 5: in_first re-asserted at bit 4
        new_word();
        for (int k = 0; k < 4; k++) drive_bit(k, k == 0);
        new_word();
        full_word();

        // 6: reset for one cycle at bit 5
        new_word();
        for (int k = 0; k < 5; k++) drive_bit(k, k == 0);
        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_first = 1'b0;
        for (int i = 0; i < NL; i++) begin
            bus.a_bits[i] = wa[i][5];
            bus.b_bits[i] = wb[i][5];
        end
        step();
        chk("t6_valid", 32'(bus.out_valid), 32'(0));
        chk("t6_first", 32'(bus.out_first), 32'(0));
        chk("t6_last",  32'(bus.out_last),  32'(0));
        chk("t6_sum",   32'(bus.sum_bits),  32'(0));
        chk("t6_ovf",   32'(bus.ovf),       32'(0));
        chk("t6_state", 32'(fsm_state),     32'(IDLE));
        reset_n  = 1'b1;
        last_sum = '0;
        for (int s = 0; s < 3; s++) idle_cycle(1'b1, IDLE);
        new_word();
        full_word();

        // Random words with gaps, stalls and abandoned words
        for (int w = 0; w < 40; w++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle(1'($urandom), IDLE);
            new_word();
            abort = ($urandom_range(0, 5) == 0);
            if (abort) begin
                p = $urandom_range(1, WB - 1);
                for (int k = 0; k < p; k++) begin
                    if (k > 0 && $urandom_range(0, 4) == 0) idle_cycle(1'b0, RUN);
                    drive_bit(k, k == 0);
                end
                new_word();
            end
            for (int k = 0; k < WB; k++) begin
                if (k > 0 && $urandom_range(0, 4) == 0) begin
                    for (int s = 0; s < $urandom_range(1, 2); s++) idle_cycle(1'b0, RUN);
                end
                drive_bit(k, k == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
